// File: rtl/mat_job_ctrl.sv
// Job sequencer between the UART and the 2x2 matrix multiplier: parses framed A/B
// operand packets, waits MUL_LATENCY+1 cycles for the product, streams a 6-byte result.
// Latency: result capture MUL_LATENCY+1 cycles after last B byte; TX held on !tx_ready.
module mat_job_ctrl #(
    parameter int         MUL_LATENCY = 1,
    parameter int         TIMEOUT     = 120000,
    parameter logic [7:0] HDR         = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] mat_a,
    output logic [31:0] mat_b,
    input  logic [31:0] c_in,
    output logic        busy,
    output logic        err,
    output logic [7:0]  job_id
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(MUL_LATENCY + 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_JOB  = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_COMP = 3'd4;
    localparam logic [2:0] S_SEND = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          sel_b_q, sel_b_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_valid_q, a_valid_d;
    logic [7:0]    job_q, job_d;
    logic [31:0]   mat_a_q, mat_a_d;
    logic [31:0]   mat_b_q, mat_b_d;
    logic [31:0]   res_q, res_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_valid_q, tx_valid_d;
    logic          err_q, err_d;
    logic [7:0]    tx_next;

    // Byte that follows the one at tx_idx_q in the result frame.
    always_comb begin
        tx_next = res_q[31:24];
        case (tx_idx_q)
            3'd0:    tx_next = job_q;
            3'd1:    tx_next = res_q[7:0];
            3'd2:    tx_next = res_q[15:8];
            3'd3:    tx_next = res_q[23:16];
            default: tx_next = res_q[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_b_d    = sel_b_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        a_valid_d  = a_valid_q;
        job_d      = job_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        res_d      = res_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == HDR) begin
                    state_d = S_SEL;
                    timer_d = '0;
                end
            end
            S_SEL, S_JOB, S_LOAD: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (state_q == S_SEL) begin
                        if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                            sel_b_d = rx_byte[0];
                            state_d = S_JOB;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (state_q == S_JOB) begin
                        if (!sel_b_q) begin
                            job_d     = rx_byte;
                            a_valid_d = 1'b0;
                            idx_d     = 2'd0;
                            state_d   = S_LOAD;
                        end else if (a_valid_q && rx_byte == job_q) begin
                            idx_d   = 2'd0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        // Payload bytes are taken verbatim, HDR included.
                        if (sel_b_q) mat_b_d[{idx_q, 3'b000} +: 8] = rx_byte;
                        else         mat_a_d[{idx_q, 3'b000} +: 8] = rx_byte;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (sel_b_q) begin
                                state_d = S_COMP;
                                cnt_d   = '0;
                            end else begin
                                a_valid_d = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_COMP: begin
                if (rx_valid) err_d = 1'b1;
                if (cnt_q == CW'(MUL_LATENCY)) begin
                    res_d      = c_in;
                    tx_byte_d  = HDR;
                    tx_valid_d = 1'b1;
                    tx_idx_d   = 3'd0;
                    state_d    = S_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEND: begin
                if (rx_valid) err_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    if (tx_idx_q == 3'd5) begin
                        tx_valid_d = 1'b0;
                        a_valid_d  = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_idx_d  = tx_idx_q + 3'd1;
                        tx_byte_d = tx_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_b_q    <= 1'b0;
            idx_q      <= 2'd0;
            timer_q    <= '0;
            cnt_q      <= '0;
            a_valid_q  <= 1'b0;
            job_q      <= 8'h00;
            mat_a_q    <= 32'h0;
            mat_b_q    <= 32'h0;
            res_q      <= 32'h0;
            tx_idx_q   <= 3'd0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_b_q    <= sel_b_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            a_valid_q  <= a_valid_d;
            job_q      <= job_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            res_q      <= res_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign mat_a    = mat_a_q;
    assign mat_b    = mat_b_q;
    assign job_id   = job_q;
    assign err      = err_q;
    assign busy     = (state_q == S_COMP) || (state_q == S_SEND);

endmodule
